// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Turns loads/stores into word-aligned, byte-enabled req/ack bus transfers,
// extends load data, stalls the pipeline during the transfer and flags
// misaligned/illegal accesses and bus timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        exc_misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  type_q;
    logic [1:0]  addr_lo_q;
    logic [7:0]  cnt_q;
    logic        type_ok, align_ok, legal, accept, timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Classify the incoming request: known type code and natural alignment
    always_comb begin
        type_ok  = 1'b0;
        align_ok = 1'b0;
        case (req_type)
            3'b000: begin
                type_ok  = 1'b1;
                align_ok = (req_addr[1:0] == 2'b00);
            end
            3'b010, 3'b011: begin
                type_ok  = 1'b1;
                align_ok = ~req_addr[0];
            end
            3'b100, 3'b101: begin
                type_ok  = 1'b1;
                align_ok = 1'b1;
            end
            default: ;
        endcase
    end

    assign legal       = type_ok & align_ok;
    assign accept      = (state_q == IDLE) & req_valid & legal;
    assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = req_wdata;
        case (req_type[2:1])
            2'b00: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata;
            end
            2'b01: begin
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection and extension of returning load data
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (type_q)
            3'b010:  load_ext = {16'h0000, half_sel};
            3'b011:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b101:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an ack in the timeout cycle still completes the access
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUS;
            BUS: begin
                if (bus_ack)          state_d = DONE;
                else if (timeout_hit) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; stall rises combinationally on acceptance
    always_comb begin
        stall   = accept | (state_q == BUS);
        done    = (state_q == DONE);
        bus_err = (state_q == ERR);
        bus_req = (state_q == BUS);
        bus_we  = (state_q == BUS) & we_q;
    end

    // Request capture, bus attribute hold, timeout counter and load result
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q         <= 1'b0;
            type_q       <= '0;
            addr_lo_q    <= '0;
            cnt_q        <= '0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            rdata_out    <= '0;
            exc_misalign <= 1'b0;
        end else begin
            exc_misalign <= (state_q == IDLE) & req_valid & ~legal;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_write;
                        type_q    <= req_type;
                        addr_lo_q <= req_addr[1:0];
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_be    <= be_d;
                        bus_wdata <= wdata_d;
                        cnt_q     <= '0;
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        if (!we_q) rdata_out <= load_ext;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, done, exc_misalign, bus_err, bus_req, bus_we;
    logic [31:0] rdata_out, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    int n_stall, n_done, n_req, n_exc, n_err;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_req;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata_out(rdata_out),
        .exc_misalign(exc_misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Per-cycle event counters, sampled mid-low-phase
    always @(negedge clk) begin
        #2;
        if (stall)        n_stall++;
        if (done)         n_done++;
        if (bus_req)      n_req++;
        if (exc_misalign) n_exc++;
        if (bus_err)      n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic clear_counts();
        n_stall = 0; n_done = 0; n_req = 0; n_exc = 0; n_err = 0;
    endtask

    // One legal access acked after `waits` wait cycles
    task automatic access(input logic w, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic [31:0] rd);
        @(negedge clk);
        clear_counts();
        req_valid = 1'b1; req_write = w; req_type = t; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be;
        cap_we = bus_we; cap_req = bus_req;
        repeat (waits) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        #3;
    endtask

    // One request expected to be rejected
    task automatic bad_access(input logic [2:0] t, input logic [31:0] a);
        @(negedge clk);
        clear_counts();
        req_valid = 1'b1; req_write = 1'b0; req_type = t; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #3;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_rdata", rdata_out, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Word load, two wait cycles
        access(1'b0, 3'b000, 32'h0000_0010, 32'h0, 2, 32'hDEADBEEF);
        check("wl_be", 32'(cap_be), 32'hF);
        check("wl_addr", cap_addr, 32'h10);
        check("wl_req", 32'(cap_req), 32'd1);
        check("wl_stall_cycles", n_stall, 4);
        check("wl_done_pulses", n_done, 1);
        check("wl_req_cycles", n_req, 3);
        check("wl_rdata", rdata_out, 32'hDEADBEEF);

        // Signed and unsigned byte loads from lane 3
        access(1'b0, 3'b101, 32'h0000_0013, 32'h0, 1, 32'h80112233);
        check("lbs_be", 32'(cap_be), 32'h8);
        check("lbs_addr", cap_addr, 32'h10);
        check("lbs_rdata", rdata_out, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h0000_0013, 32'h0, 0, 32'h80112233);
        check("lbu_rdata", rdata_out, 32'h00000080);

        // Half store, zero-wait
        access(1'b1, 3'b010, 32'h0000_0022, 32'h1234ABCD, 0, 32'hFFFF_FFFF);
        check("sh_we", 32'(cap_we), 32'd1);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        check("sh_addr", cap_addr, 32'h20);
        check("sh_rdata_kept", rdata_out, 32'h00000080);
        check("sh_stall_cycles", n_stall, 2);

        // Byte store (signed code) to lane 1
        access(1'b1, 3'b101, 32'h0000_0021, 32'hFFFF_FF5A, 0, 32'h0);
        check("sb_be", 32'(cap_be), 32'h2);
        check("sb_wdata", cap_wdata, 32'h5A5A5A5A);
        check("sb_rdata_kept", rdata_out, 32'h00000080);

        // Signed half load from upper half
        access(1'b0, 3'b011, 32'h0000_0012, 32'h0, 0, 32'h80112233);
        check("lhs_be", 32'(cap_be), 32'hC);
        check("lhs_we", 32'(cap_we), 32'd0);
        check("lhs_rdata", rdata_out, 32'hFFFF8011);

        // Rejected requests
        bad_access(3'b000, 32'h0000_0006);
        check("mis_word_exc", n_exc, 1);
        check("mis_word_req", n_req, 0);
        check("mis_word_stall", n_stall, 0);
        bad_access(3'b110, 32'h0000_0000);
        check("bad_type_exc", n_exc, 1);
        check("bad_type_req", n_req, 0);
        check("bad_type_stall", n_stall, 0);
        bad_access(3'b011, 32'h0000_0013);
        check("mis_half_exc", n_exc, 1);
        check("mis_half_req", n_req, 0);

        // Timeout with a late ack
        @(negedge clk);
        clear_counts();
        req_valid = 1'b1; req_write = 1'b0; req_type = 3'b000; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #3;
        check("to_req_cycles", n_req, 4);
        check("to_stall_cycles", n_stall, 5);
        check("to_err_pulses", n_err, 1);
        check("to_done_pulses", n_done, 0);
        check("to_rdata_kept", rdata_out, 32'hFFFF8011);

        // Reset in the second BUS cycle
        @(negedge clk);
        clear_counts();
        req_valid = 1'b1; req_write = 1'b0; req_type = 3'b000; req_addr = 32'h50;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mr_bus_req", 32'(bus_req), 32'd0);
        check("mr_stall", 32'(stall), 32'd0);
        check("mr_rdata", rdata_out, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #3;
        check("mr_no_done", n_done, 0);
        check("mr_rdata_after_ack", rdata_out, 32'h0);
        access(1'b0, 3'b000, 32'h0000_0054, 32'h0, 0, 32'hCAFEF00D);
        check("mr_next_addr", cap_addr, 32'h54);
        check("mr_next_rdata", rdata_out, 32'hCAFEF00D);
        check("mr_next_done", n_done, 1);
        check("mr_next_stall", n_stall, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access unit in the MEM stage. It consumes the memory control from the control unit: MemWrite, MemtoReg, and DataType.
- Translates each load or store into a word-aligned, byte-enabled request on a variable-latency req/ack memory bus.
- Sign- or zero-extends load data.
- Holds the pipeline stall high until the bus access completes.
- Flags misaligned accesses, illegal DataType codes, and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of BUS-state cycles without bus_ack before the access is aborted; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  input  1  a memory instruction is in MEM (MemWrite | MemtoReg).
- req_write  input  1  1 = store, 0 = load.
- req_type  input  3  DataType: 000 word, 010 half-unsigned/store-half, 011 half-signed, 100 byte-unsigned/store-byte, 101 byte-signed.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the value is right-aligned in the low bits.
- stall  output  1  freeze the pipeline.
- done  output  1  one-cycle pulse; the access has completed.
- rdata_out  output  32  extended load result.
- exc_misalign  output  1  one-cycle pulse: misaligned address or illegal req_type.
- bus_err  output  1  one-cycle pulse: the access timed out.
- bus_req  output  1  bus request.
- bus_we  output  1  bus write.
- bus_addr  output  32  word address: {req_addr[31:2], 2'b00}.
- bus_be  output  4  byte enables; bit k selects bits 8k+7:8k.
- bus_wdata  output  32  lane-replicated store data.
- bus_ack  input  1  memory completed the request this cycle.
- bus_rdata  input  32  read data; valid when bus_ack = 1.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - State returns to IDLE.
  - All outputs go to 0, including rdata_out, bus_be, bus_addr, and bus_wdata.
  - A reset during BUS drops bus_req on that same edge; a later bus_ack is ignored.
- States: IDLE, BUS, DONE, ERR.
- Request checking in IDLE (combinational):
  - An access is illegal if req_type is not one of the five codes listed under Ports.
  - An access is also illegal if it is misaligned:
    - word with addr[1:0] != 0;
    - half with addr[0] != 0.
  - Stores use the type groups "word", "half" (010/011), and "byte" (100/101); the signedness bit is ignored for stores.
- IDLE transitions:
  - req_valid = 1 and the access is illegal: pulse exc_misalign on the next cycle and stay in IDLE. No bus activity and no stall.
  - req_valid = 1 and the access is legal:
    - stall = 1 combinationally in the same cycle;
    - on the next edge, register write/type/addr/data, drive the bus signals, set bus_req = 1, clear the timeout counter, and go to BUS.
- BUS state:
  - stall = 1.
  - bus_req, bus_we, bus_addr, bus_be, and bus_wdata are held stable until bus_ack.
  - bus_ack = 1: go to DONE; bus_req = 0 on the next cycle. For a load, register the extended bus_rdata into rdata_out.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES, go to ERR and drop bus_req.
- DONE state: done = 1, stall = 0, return to IDLE. A new request is not accepted in DONE; the pipeline advances on this cycle.
- ERR state: bus_err = 1, stall = 0, return to IDLE. rdata_out is unchanged.
- Byte enables:
  - word: bus_be = 1111;
  - half: 0011 if addr[1] = 0, else 1100;
  - byte: bus_be = 1 << addr[1:0].
- Store data:
  - word: passed through;
  - half: {wdata[15:0], wdata[15:0]};
  - byte: {4{wdata[7:0]}}.
- Load data:
  - Select the lane given by the registered addr, then zero-extend (010, 100) or sign-extend (011, 101).
  - rdata_out holds its value until the next completed load; stores leave it unchanged.
- Boundary conditions:
  - bus_ack in IDLE, DONE, or ERR is ignored.
  - bus_ack on the same cycle the counter reaches TIMEOUT_CYCLES: the ack wins.
  - Latency: minimum 3 cycles from acceptance to done, with a 0-wait memory (ack in the first BUS cycle).

Test Plan:
- Word load, addr 0x0000_0010, ack after 2 wait cycles with bus_rdata 0xDEADBEEF:
  - bus_be = 1111 and bus_addr = 0x10;
  - stall high for 4 cycles (acceptance cycle + 3 BUS cycles); done pulses once;
  - rdata_out = 0xDEADBEEF.
- Signed byte load (101), addr 0x13, bus_rdata 0x80_11_22_33:
  - bus_be = 1000;
  - rdata_out = 0xFFFFFF80.
  - Repeat with 100: rdata_out = 0x00000080.
- Store half (010), addr 0x22, wdata 0x1234ABCD, 0-wait ack:
  - bus_we = 1, bus_be = 1100, bus_wdata = 0xABCDABCD;
  - rdata_out unchanged.
- Misaligned word load at 0x06, and separately req_type 110:
  - exc_misalign pulses;
  - bus_req never asserts; stall stays 0.
- TIMEOUT_CYCLES = 4, no ack:
  - bus_req drops after 4 BUS cycles;
  - bus_err pulses; stall falls;
  - a late bus_ack is ignored.
- Reset asserted (reset = 0) in the second BUS cycle:
  - next edge: bus_req = 0, stall = 0, state IDLE;
  - a subsequent legal request completes normally.
